// File: rtl/agat_gcr_pkg.sv
// agat_gcr_pkg
//   Shared definitions for the Agat/Apple GCR address and data field decoders:
//   parser state encoding, address epilogue bytes, format_type codes and the
//   4&4 pair decode function.
package agat_gcr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIELD = 2'd1,
    ST_EPI   = 2'd2
  } agat_state_e;

  localparam logic [7:0] EPI_BYTE0     = 8'hDE;
  localparam logic [7:0] EPI_BYTE1     = 8'hAA;

  // Bits 7/5/3/1 are always set in a well-formed 4&4 byte.
  localparam logic [7:0] ODD_BITS_MASK = 8'hAA;

  localparam logic [1:0] FMT_APPLE     = 2'd0;
  localparam logic [1:0] FMT_AGAT7     = 2'd1;
  localparam logic [1:0] FMT_AGAT9     = 2'd2;

  // 4&4 decode: the first byte carries the odd data bits, the second the even.
  function automatic logic [7:0] decode_44(input logic [7:0] b_odd,
                                           input logic [7:0] b_even);
    decode_44 = {b_odd[6:0], 1'b1} & b_even;
  endfunction

endpackage

// File: rtl/agat_byte_timeout.sv
// agat_byte_timeout
//   Inter-byte watchdog. Counts clk cycles while enabled and pulses tc in the
//   cycle the count sits at TIMEOUT_CYCLES-1. A clear (or dropping en) returns
//   the count to zero; clear takes precedence over tc in the same cycle.
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     en           : count while high, held at zero while low
//     clear        : synchronous restart of the count
//     tc           : terminal-count pulse (combinational from the count)
module agat_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !en) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && !clear && (cnt_q == TC_VAL);

endmodule

// File: rtl/agat_addr_field_decoder.sv
// agat_addr_field_decoder
//   Captures the 8-byte 4&4 address field (volume, track, sector, checksum)
//   that follows an address mark, checks the XOR checksum, the odd-bit
//   encoding and (optionally) the DE AA epilogue, and publishes one registered
//   header record per complete field.
//   Build option: define AGAT_ADDR_EPILOGUE_CHECK_EN to include the epilogue
//   check state; without it hdr_valid fires after field byte 7 and
//   hdr_epilogue_ok reads 1 in every published header.
//   Ports:
//     clk, reset_n           : clock, async active-low reset
//     enable                 : block enable, low forces idle
//     byte_in, byte_valid    : assembled GCR byte and its strobe
//     addr_mark, data_mark   : prologue-end marks, coincident with byte_valid
//     format_type            : disk format, latched at addr_mark
//     hdr_valid              : one-cycle header-complete pulse
//     hdr_volume/track/sector/checksum, hdr_format : header record
//     hdr_chksum_ok, hdr_epilogue_ok, hdr_enc_ok   : header quality flags
//     busy                   : parse in progress
//     abort                  : one-cycle pulse on timeout, data_mark or enable drop
module agat_addr_field_decoder
  import agat_gcr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 2048,
  parameter int REQUIRE_ODD_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       addr_mark,
  input  logic       data_mark,
  input  logic [1:0] format_type,
  output logic       hdr_valid,
  output logic [7:0] hdr_volume,
  output logic [7:0] hdr_track,
  output logic [7:0] hdr_sector,
  output logic [7:0] hdr_checksum,
  output logic [1:0] hdr_format,
  output logic       hdr_chksum_ok,
  output logic       hdr_epilogue_ok,
  output logic       hdr_enc_ok,
  output logic       busy,
  output logic       abort
);

  agat_state_e     state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][7:0] fld_q, fld_d;
  logic [1:0]      fmt_q, fmt_d;
  logic            enc_acc_q, enc_acc_d;
  logic            epi_acc_q, epi_acc_d;

  logic            hdr_valid_q, hdr_valid_d;
  logic            abort_q, abort_d;
  logic [7:0]      hdr_volume_q, hdr_volume_d;
  logic [7:0]      hdr_track_q, hdr_track_d;
  logic [7:0]      hdr_sector_q, hdr_sector_d;
  logic [7:0]      hdr_checksum_q, hdr_checksum_d;
  logic [1:0]      hdr_format_q, hdr_format_d;
  logic            hdr_chksum_ok_q, hdr_chksum_ok_d;
  logic            hdr_epilogue_ok_q, hdr_epilogue_ok_d;
  logic            hdr_enc_ok_q, hdr_enc_ok_d;

  logic            am_strobe;
  logic            dm_strobe;
  logic            enc_byte_ok;
  logic            complete;
  logic            tmo_tc;

  assign am_strobe   = byte_valid && addr_mark;
  assign dm_strobe   = byte_valid && data_mark;
  assign enc_byte_ok = (REQUIRE_ODD_BITS == 0) ||
                       ((byte_in & ODD_BITS_MASK) == ODD_BITS_MASK);

  agat_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_q != ST_IDLE),
    .clear  (byte_valid),
    .tc     (tmo_tc)
  );

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    fld_d             = fld_q;
    fmt_d             = fmt_q;
    enc_acc_d         = enc_acc_q;
    epi_acc_d         = epi_acc_q;
    hdr_valid_d       = 1'b0;
    abort_d           = 1'b0;
    hdr_volume_d      = hdr_volume_q;
    hdr_track_d       = hdr_track_q;
    hdr_sector_d      = hdr_sector_q;
    hdr_checksum_d    = hdr_checksum_q;
    hdr_format_d      = hdr_format_q;
    hdr_chksum_ok_d   = hdr_chksum_ok_q;
    hdr_epilogue_ok_d = hdr_epilogue_ok_q;
    hdr_enc_ok_d      = hdr_enc_ok_q;
    complete          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && am_strobe) begin
          state_d   = ST_FIELD;
          idx_d     = 3'd0;
          fmt_d     = format_type;
          enc_acc_d = 1'b1;
          epi_acc_d = 1'b1;
        end
      end

      ST_FIELD, ST_EPI: begin
        if (!enable || dm_strobe || tmo_tc) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (am_strobe) begin
          // A fresh address mark restarts the field; the partial one is dropped.
          state_d   = ST_FIELD;
          idx_d     = 3'd0;
          fmt_d     = format_type;
          enc_acc_d = 1'b1;
          epi_acc_d = 1'b1;
        end else if (byte_valid) begin
          if (state_q == ST_FIELD) begin
            fld_d[idx_q] = byte_in;
            enc_acc_d    = enc_acc_q && enc_byte_ok;
            if (idx_q == 3'd7) begin
`ifdef AGAT_ADDR_EPILOGUE_CHECK_EN
              state_d = ST_EPI;
              idx_d   = 3'd0;
`else
              state_d  = ST_IDLE;
              complete = 1'b1;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            epi_acc_d = epi_acc_q &&
                        (byte_in == ((idx_q == 3'd0) ? EPI_BYTE0 : EPI_BYTE1));
            if (idx_q == 3'd0) begin
              idx_d = 3'd1;
            end else begin
              state_d  = ST_IDLE;
              complete = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // fld_d already holds the final field byte when completing straight out
    // of FIELD, so the whole record is published in one step.
    if (complete) begin
      hdr_valid_d     = 1'b1;
      hdr_volume_d    = decode_44(fld_d[0], fld_d[1]);
      hdr_track_d     = decode_44(fld_d[2], fld_d[3]);
      hdr_sector_d    = decode_44(fld_d[4], fld_d[5]);
      hdr_checksum_d  = decode_44(fld_d[6], fld_d[7]);
      hdr_format_d    = fmt_q;
      hdr_chksum_ok_d = ((hdr_volume_d ^ hdr_track_d ^ hdr_sector_d) == hdr_checksum_d);
      hdr_enc_ok_d    = enc_acc_d;
`ifdef AGAT_ADDR_EPILOGUE_CHECK_EN
      hdr_epilogue_ok_d = epi_acc_d;
`else
      hdr_epilogue_ok_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      idx_q             <= 3'd0;
      fld_q             <= '0;
      fmt_q             <= FMT_APPLE;
      enc_acc_q         <= 1'b0;
      epi_acc_q         <= 1'b0;
      hdr_valid_q       <= 1'b0;
      abort_q           <= 1'b0;
      hdr_volume_q      <= 8'h00;
      hdr_track_q       <= 8'h00;
      hdr_sector_q      <= 8'h00;
      hdr_checksum_q    <= 8'h00;
      hdr_format_q      <= FMT_APPLE;
      hdr_chksum_ok_q   <= 1'b0;
      hdr_epilogue_ok_q <= 1'b0;
      hdr_enc_ok_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      fld_q             <= fld_d;
      fmt_q             <= fmt_d;
      enc_acc_q         <= enc_acc_d;
      epi_acc_q         <= epi_acc_d;
      hdr_valid_q       <= hdr_valid_d;
      abort_q           <= abort_d;
      hdr_volume_q      <= hdr_volume_d;
      hdr_track_q       <= hdr_track_d;
      hdr_sector_q      <= hdr_sector_d;
      hdr_checksum_q    <= hdr_checksum_d;
      hdr_format_q      <= hdr_format_d;
      hdr_chksum_ok_q   <= hdr_chksum_ok_d;
      hdr_epilogue_ok_q <= hdr_epilogue_ok_d;
      hdr_enc_ok_q      <= hdr_enc_ok_d;
    end
  end

  assign hdr_valid       = hdr_valid_q;
  assign abort           = abort_q;
  assign hdr_volume      = hdr_volume_q;
  assign hdr_track       = hdr_track_q;
  assign hdr_sector      = hdr_sector_q;
  assign hdr_checksum    = hdr_checksum_q;
  assign hdr_format      = hdr_format_q;
  assign hdr_chksum_ok   = hdr_chksum_ok_q;
  assign hdr_epilogue_ok = hdr_epilogue_ok_q;
  assign hdr_enc_ok      = hdr_enc_ok_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/agat_addr_field_decoder.md
# agat_addr_field_decoder

Downstream consumer of the Agat/Apple GCR sync detector. It takes the assembled byte stream plus the address-mark strobe and captures the 8-byte 4&4-encoded address field: volume, track, sector and checksum. It verifies the XOR checksum and the DE AA epilogue, then presents one registered header record per field to the sector sequencer.

## Interface
- `TIMEOUT_CYCLES`, default 2048: clk cycles allowed between consecutive field bytes before the parse aborts; must be ≥ 2.
- `REQUIRE_ODD_BITS`, default 1: when 1, any field byte whose bits 7/5/3/1 are not all 1 clears `hdr_enc_ok`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: block enable; low forces IDLE.
- `byte_in` in 8: assembled GCR byte.
- `byte_valid` in 1: one-cycle strobe; `byte_in` is valid.
- `addr_mark` in 1: coincident with the `byte_valid` of the prologue-end byte.
- `data_mark` in 1: coincident with the `byte_valid` of the data prologue-end byte.
- `format_type` in 2: 0=Apple, 1=Agat-7, 2=Agat-9; sampled with `addr_mark`.
- `hdr_valid` out 1: one-cycle header-complete pulse.
- `hdr_volume`, `hdr_track`, `hdr_sector`, `hdr_checksum` out 8 each: decoded fields, held until the next `hdr_valid`.
- `hdr_format` out 2: `format_type` latched at `addr_mark`.
- `hdr_chksum_ok` out 1: volume^track^sector == checksum.
- `hdr_epilogue_ok` out 1: epilogue matched DE AA.
- `hdr_enc_ok` out 1: all 8 field bytes passed the odd-bit check.
- `busy` out 1: high in FIELD or EPI.
- `abort` out 1: one-cycle pulse on timeout, `data_mark` mid-parse, or `enable` drop mid-parse.

## Operation
- States: IDLE, FIELD (byte index 0..7), EPI (index 0..1).
- IDLE → FIELD on `enable & byte_valid & addr_mark`. Entering FIELD:
  - latch `format_type`;
  - clear the index and the timeout counter;
  - set the encoding-ok accumulator.
  - The prologue byte itself is not field data.
- FIELD, each `byte_valid` stores `byte_in` into pair slot index/2 (even index = odd-bits byte, odd index = even-bits byte).
- Decoding: value = ((b_odd << 1) | 8'h01) & b_even, truncated to 8 bits.
- After index 7, go to EPI. Compare epilogue byte 0 with DE and byte 1 with AA, accumulating the result.
- Completing EPI index 1: pulse `hdr_valid`, update all `hdr_*` outputs together, return to IDLE.
- `addr_mark` during FIELD or EPI restarts FIELD at index 0. No `abort`, no `hdr_valid`.
- `data_mark` during FIELD or EPI pulses `abort` and goes to IDLE. `hdr_*` are unchanged.
- Timeout:
  - the counter increments every cycle in FIELD/EPI and clears on each `byte_valid`;
  - reaching `TIMEOUT_CYCLES-1` pulses `abort` and goes to IDLE.
- `enable` low in FIELD/EPI pulses `abort` once and goes to IDLE. In IDLE, `enable` low is silent.
- `hdr_*` outputs change only on `hdr_valid`. A previous header is never partially overwritten.

## Timing
- Reset (asynchronous assertion, synchronous release): IDLE; all outputs 0, including the ok flags and `hdr_*`.
- `hdr_valid` asserts the cycle after the final consumed `byte_valid` (registered). The data on `hdr_*` is valid in that same cycle.
- `abort` is registered: it asserts one cycle after the triggering event or the timeout terminal count.
- `busy` rises the cycle after `addr_mark` and falls in the same cycle `hdr_valid` or `abort` asserts.
- Back-to-back: an `addr_mark` on the cycle after the final byte is accepted. No dead cycles are required.
- Reset mid-parse discards all partial state immediately.

## Configuration
- `AGAT_ADDR_EPILOGUE_CHECK_EN`
  - Defined: EPI state present; behaviour as above.
  - Undefined: EPI removed; `hdr_valid` fires after field byte 7 and `hdr_epilogue_ok` is tied 1.

## Structure
- Shared package `agat_gcr_pkg`:
  - state encoding;
  - epilogue constants DE/AA;
  - `format_type` codes;
  - a `decode_44` function, to be reused by the data-field decoder.
- One natural sub-module, `agat_byte_timeout`: a counter with clear, enable and terminal-count pulse, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Nominal header, Apple format: `addr_mark`, then FF FE AA BB AA AF FF EA DE AA → `hdr_valid` with volume FE, track 11, sector 05, checksum EA; `chksum_ok`=1, `epilogue_ok`=1, `enc_ok`=1.
- Last checksum byte changed to EB → checksum reads EB and `chksum_ok`=0; other flags 1.
- Epilogue DE AB → `epilogue_ok`=0. With the macro undefined, `hdr_valid` fires 1 cycle after byte EA.
- Timeout: bytes stop after index 3 → `abort` after `TIMEOUT_CYCLES`, no `hdr_valid`, previous `hdr_*` retained.
- Second `addr_mark` at index 5, then the full nominal field with `format_type`=1 → exactly one `hdr_valid`, `hdr_format`=1; byte 2 = 2A with `REQUIRE_ODD_BITS`=1 → `enc_ok`=0.
- Reset and `data_mark` mid-parse:
  - `reset_n` low at index 4 → all outputs 0 while reset is asserted;
  - `data_mark` at index 6 → one `abort` pulse, `busy` drops.
